// File: rtl/fiqsha_ahb_slave_adapter.sv
// fiqsha_ahb_slave_adapter: AHB-Lite slave front-end to the native FIQSHA write-strobe / combinational-read handshake
`ifndef FIQSHA_BUS
`define FIQSHA_BUS 32
`endif
module fiqsha_ahb_slave_adapter #(
    parameter int FIQSHA_BUS_DATA_WIDTH = `FIQSHA_BUS,
    parameter int TIMEOUT_CYCLES        = 16
) (
    input  logic                             clk_i,
    input  logic                             resetn_i,
    input  logic                             hsel_i,
    input  logic [11:0]                      haddr_i,
    input  logic [1:0]                       htrans_i,
    input  logic                             hwrite_i,
    input  logic [2:0]                       hsize_i,
    input  logic [2:0]                       hburst_i,
    input  logic                             hready_i,
    input  logic [FIQSHA_BUS_DATA_WIDTH-1:0] hwdata_i,
    output logic [FIQSHA_BUS_DATA_WIDTH-1:0] hrdata_o,
    output logic                             hreadyout_o,
    output logic                             hresp_o,
    output logic                             wr_o,
    input  logic                             wr_ack_i,
    output logic [11:0]                      waddr_o,
    output logic [FIQSHA_BUS_DATA_WIDTH-1:0] wdata_o,
    output logic                             rd_o,
    output logic                             rd_ack_o,
    output logic [11:0]                      raddr_o,
    input  logic [FIQSHA_BUS_DATA_WIDTH-1:0] rdata_i,
    input  logic                             read_valid_i,
    input  logic                             slv_error_i,
    output logic [1:0]                       burst_type_o
);
    localparam int SZ = (FIQSHA_BUS_DATA_WIDTH == 64) ? 3 : 2;
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD, ERR1, ERR2} state_t;
    state_t state_q, state_d, fin;
    logic [11:0] addr_q, addr_d;
    logic [1:0] burst_q, burst_d;
    logic [7:0] cnt_q, cnt_d;
    logic accept, legal, tmo, counting, unused;
    assign unused = htrans_i[0];
    // Only sample a new address phase on cycles where this slave itself is completing
    assign accept = hsel_i & htrans_i[1] & hready_i & hreadyout_o;
    assign legal = (hsize_i == 3'(SZ)) && (haddr_i[SZ-1:0] == '0);
    assign tmo = cnt_q >= 8'(TIMEOUT_CYCLES - 1);
    assign counting = (state_q == WR_WAIT && !wr_ack_i) || (state_q == RD && !read_valid_i);
    assign fin = !accept ? IDLE : !legal ? ERR1 : hwrite_i ? WR_REQ : RD;
    assign hreadyout_o = (state_q == WR_REQ || state_q == ERR1) ? 1'b0 :
                         (state_q == WR_WAIT) ? (wr_ack_i & ~slv_error_i) :
                         (state_q == RD) ? read_valid_i : 1'b1;
    assign hresp_o = (state_q == ERR1) || (state_q == ERR2);
    assign wr_o = state_q == WR_REQ;
    assign rd_o = state_q == RD;
    assign rd_ack_o = rd_o & read_valid_i;
    assign hrdata_o = rd_o ? rdata_i : '0;
    assign wdata_o = hwdata_i;
    assign waddr_o = addr_q;
    assign raddr_o = addr_q;
    assign burst_type_o = burst_q;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ERR2: state_d = fin;
            WR_REQ:     state_d = WR_WAIT;
            WR_WAIT:    state_d = wr_ack_i ? (slv_error_i ? ERR1 : fin) : (tmo ? ERR1 : WR_WAIT);
            RD:         state_d = read_valid_i ? fin : (tmo ? ERR1 : RD);
            ERR1:       state_d = ERR2;
            default:    state_d = IDLE;
        endcase
        addr_d = accept ? haddr_i : addr_q;
        burst_d = !accept ? burst_q :
                  (hburst_i == 3'd0) ? 2'b00 :
                  (hburst_i == 3'd1) ? 2'b01 :
                  hburst_i[0] ? 2'b10 : 2'b11;
        cnt_d = !counting ? 8'd0 : (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_fiqsha_ahb_slave_adapter.sv
// tb_fiqsha_ahb_slave_adapter: directed checks of the AHB-Lite slave adapter against hand-computed values
module tb_fiqsha_ahb_slave_adapter;
    localparam int W = 32;
    logic clk_i = 1'b0;
    logic resetn_i = 1'b0;
    logic hsel_i, hwrite_i, hready_i, hreadyout_o, hresp_o;
    logic [11:0] haddr_i, waddr_o, raddr_o;
    logic [1:0] htrans_i, burst_type_o;
    logic [2:0] hsize_i, hburst_i;
    logic [W-1:0] hwdata_i, hrdata_o, wdata_o, rdata_i;
    logic wr_o, wr_ack_i, rd_o, rd_ack_o, read_valid_i, slv_error_i, rv_en;
    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int base;

    fiqsha_ahb_slave_adapter #(.FIQSHA_BUS_DATA_WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_i), .resetn_i(resetn_i), .hsel_i(hsel_i), .haddr_i(haddr_i),
        .htrans_i(htrans_i), .hwrite_i(hwrite_i), .hsize_i(hsize_i), .hburst_i(hburst_i),
        .hready_i(hready_i), .hwdata_i(hwdata_i), .hrdata_o(hrdata_o), .hreadyout_o(hreadyout_o),
        .hresp_o(hresp_o), .wr_o(wr_o), .wr_ack_i(wr_ack_i), .waddr_o(waddr_o), .wdata_o(wdata_o),
        .rd_o(rd_o), .rd_ack_o(rd_ack_o), .raddr_o(raddr_o), .rdata_i(rdata_i),
        .read_valid_i(read_valid_i), .slv_error_i(slv_error_i), .burst_type_o(burst_type_o)
    );

    always #5 clk_i = ~clk_i;
    // Single-slave bus: the mux ready is this slave's ready; native reads decode combinationally
    assign hready_i = hreadyout_o;
    assign read_valid_i = rd_o & rv_en;
    always @(posedge clk_i) if (wr_o) wr_cnt <= wr_cnt + 1;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [11:0] addr, input logic [2:0] burst);
        hsel_i = sel;
        htrans_i = trans;
        hwrite_i = wr;
        haddr_i = addr;
        hburst_i = burst;
    endtask

    initial begin
        bus(0, 2'd0, 0, 12'h000, 3'd0);
        hsize_i = 3'd2; hwdata_i = '0; wr_ack_i = 0; slv_error_i = 0; rv_en = 0; rdata_i = '0;
        @(negedge clk_i);
        chk("rst_hready", hreadyout_o, 1);
        chk("rst_hresp", hresp_o, 0);
        chk("rst_wr", wr_o, 0);
        chk("rst_rd", rd_o, 0);
        chk("rst_rdack", rd_ack_o, 0);
        chk("rst_waddr", waddr_o, 0);
        chk("rst_raddr", raddr_o, 0);
        chk("rst_burst", burst_type_o, 0);
        chk("rst_hrdata", hrdata_o, 0);
        nxt();
        resetn_i = 1;
        // Unselected NONSEQ: ignored, zero-wait OKAY
        bus(0, 2'd2, 1, 12'h020, 3'd0);
        nxt();
        bus(0, 2'd0, 0, 12'h000, 3'd0);
        @(negedge clk_i);
        chk("unsel_wr", wr_o, 0);
        chk("unsel_hready", hreadyout_o, 1);
        // Single write 0x020, ack one cycle after the strobe
        base = wr_cnt;
        nxt();
        bus(1, 2'd2, 1, 12'h020, 3'd0);
        @(negedge clk_i);
        chk("w1_addr_hready", hreadyout_o, 1);
        nxt();
        bus(0, 2'd0, 0, 12'h000, 3'd0);
        hwdata_i = 32'h0000_0001;
        @(negedge clk_i);
        chk("w1_wr", wr_o, 1);
        chk("w1_waddr", waddr_o, 12'h020);
        chk("w1_wdata", wdata_o, 32'h1);
        chk("w1_wait", hreadyout_o, 0);
        chk("w1_burst", burst_type_o, 2'b00);
        nxt();
        wr_ack_i = 1;
        @(negedge clk_i);
        chk("w1_wr_drop", wr_o, 0);
        chk("w1_done", hreadyout_o, 1);
        chk("w1_okay", hresp_o, 0);
        nxt();
        wr_ack_i = 0;
        @(negedge clk_i);
        chk("w1_idle_wr", wr_o, 0);
        chk("w1_idle_hready", hreadyout_o, 1);
        chk("w1_pulses", 32'(wr_cnt - base), 1);
        // Zero-wait read 0x030
        nxt();
        bus(1, 2'd2, 0, 12'h030, 3'd0);
        nxt();
        bus(0, 2'd0, 0, 12'h000, 3'd0);
        rv_en = 1; rdata_i = 32'h0000_0003;
        @(negedge clk_i);
        chk("r1_rd", rd_o, 1);
        chk("r1_raddr", raddr_o, 12'h030);
        chk("r1_hrdata", hrdata_o, 32'h3);
        chk("r1_hready", hreadyout_o, 1);
        chk("r1_rdack", rd_ack_o, 1);
        nxt();
        @(negedge clk_i);
        chk("r1_rdack_drop", rd_ack_o, 0);
        chk("r1_hrdata_idle", hrdata_o, 0);
        // Read 0x0F0 never answered: 16 wait cycles, then two-cycle ERROR
        nxt();
        rv_en = 0;
        bus(1, 2'd2, 0, 12'h0F0, 3'd0);
        nxt();
        bus(0, 2'd0, 0, 12'h000, 3'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            chk($sformatf("to_wait%0d", i), {hreadyout_o, rd_o, hresp_o}, 3'b010);
            nxt();
        end
        @(negedge clk_i);
        chk("to_err1", {hreadyout_o, rd_o, hresp_o}, 3'b001);
        nxt();
        @(negedge clk_i);
        chk("to_err2", {hreadyout_o, rd_o, hresp_o}, 3'b101);
        nxt();
        @(negedge clk_i);
        chk("to_idle", {hreadyout_o, hresp_o}, 2'b10);
        // Write 0x140 with native slave error
        base = wr_cnt;
        nxt();
        bus(1, 2'd2, 1, 12'h140, 3'd0);
        nxt();
        bus(0, 2'd0, 0, 12'h000, 3'd0);
        hwdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i);
        chk("we_wr", wr_o, 1);
        nxt();
        wr_ack_i = 1; slv_error_i = 1;
        @(negedge clk_i);
        chk("we_ack_hready", hreadyout_o, 0);
        chk("we_ack_wr", wr_o, 0);
        nxt();
        wr_ack_i = 0; slv_error_i = 0;
        @(negedge clk_i);
        chk("we_err1", {hreadyout_o, hresp_o, wr_o}, 3'b010);
        nxt();
        @(negedge clk_i);
        chk("we_err2", {hreadyout_o, hresp_o, wr_o}, 3'b110);
        chk("we_pulses", 32'(wr_cnt - base), 1);
        // Misaligned address and illegal size: ERROR without native strobes
        base = wr_cnt;
        nxt();
        bus(1, 2'd2, 1, 12'h022, 3'd0);
        nxt();
        bus(0, 2'd0, 0, 12'h000, 3'd0);
        @(negedge clk_i);
        chk("mis_err1", {hreadyout_o, hresp_o, wr_o, rd_o}, 4'b0100);
        nxt();
        @(negedge clk_i);
        chk("mis_err2", {hreadyout_o, hresp_o, wr_o, rd_o}, 4'b1100);
        nxt();
        bus(1, 2'd2, 0, 12'h030, 3'd0);
        hsize_i = 3'd1;
        nxt();
        bus(0, 2'd0, 0, 12'h000, 3'd0);
        hsize_i = 3'd2;
        rv_en = 1;
        @(negedge clk_i);
        chk("sz_err1", {hreadyout_o, hresp_o, wr_o, rd_o}, 4'b0100);
        nxt();
        @(negedge clk_i);
        chk("sz_err2", {hreadyout_o, hresp_o, wr_o, rd_o}, 4'b1100);
        chk("illegal_pulses", 32'(wr_cnt - base), 0);
        // INCR4 write burst with pipelined read of 0x030 on the last completing edge
        base = wr_cnt;
        nxt();
        rv_en = 0;
        bus(1, 2'd2, 1, 12'h140, 3'd3);
        nxt();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) bus(1, 2'd3, 1, 12'(12'h140 + 4 * (i + 1)), 3'd3);
            else bus(1, 2'd2, 0, 12'h030, 3'd0);
            hwdata_i = 32'(32'hA0 + i);
            @(negedge clk_i);
            chk($sformatf("b%0d_wr", i), wr_o, 1);
            chk($sformatf("b%0d_waddr", i), waddr_o, 12'(12'h140 + 4 * i));
            chk($sformatf("b%0d_wdata", i), wdata_o, 32'(32'hA0 + i));
            chk($sformatf("b%0d_burst", i), burst_type_o, 2'b10);
            chk($sformatf("b%0d_wait", i), hreadyout_o, 0);
            nxt();
            wr_ack_i = 1;
            @(negedge clk_i);
            chk($sformatf("b%0d_done", i), {hreadyout_o, wr_o, hresp_o}, 3'b100);
            nxt();
            wr_ack_i = 0;
        end
        bus(0, 2'd0, 0, 12'h000, 3'd0);
        rv_en = 1; rdata_i = 32'h0000_0003;
        @(negedge clk_i);
        chk("bp_rd", rd_o, 1);
        chk("bp_raddr", raddr_o, 12'h030);
        chk("bp_hrdata", hrdata_o, 32'h3);
        chk("bp_burst", burst_type_o, 2'b00);
        chk("bp_hready", hreadyout_o, 1);
        chk("burst_pulses", 32'(wr_cnt - base), 4);
        // Asynchronous reset in the middle of a write wait
        nxt();
        rv_en = 0;
        bus(1, 2'd2, 1, 12'h020, 3'd1);
        nxt();
        bus(0, 2'd0, 0, 12'h000, 3'd0);
        hwdata_i = 32'h5;
        @(negedge clk_i);
        chk("ar_wr", wr_o, 1);
        chk("ar_burst", burst_type_o, 2'b01);
        nxt();
        @(negedge clk_i);
        chk("ar_wait", hreadyout_o, 0);
        #1;
        resetn_i = 0;
        #1;
        chk("ar_hready", hreadyout_o, 1);
        chk("ar_wr_low", wr_o, 0);
        chk("ar_hresp", hresp_o, 0);
        chk("ar_burst_clr", burst_type_o, 2'b00);
        nxt();
        resetn_i = 1;
        @(negedge clk_i);
        chk("ar_idle", {hreadyout_o, hresp_o, wr_o, rd_o}, 4'b1000);
        chk("ar_waddr", waddr_o, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fiqsha_ahb_slave_adapter.md
Name: fiqsha_ahb_slave_adapter

Overview:
AHB-Lite slave front-end for the FIQSHA register block. It converts pipelined AHB address/data phases into the native single-pulse write / combinational read handshake consumed by the interface control logic. It inserts wait states until the native side acknowledges, and returns AHB ERROR on native slave errors, illegal size/alignment, or handshake timeout. It sits directly upstream of the control logic on the bus side.

Parameters:
FIQSHA_BUS_DATA_WIDTH, `FIQSHA_BUS (32), AHB/native data width; legal values 32 or 64.
TIMEOUT_CYCLES, 16, maximum wait cycles for wr_ack_i / read_valid_i before ERROR; legal range 2..255.

Ports:
clk_i  in  1  clock
resetn_i  in  1  asynchronous active-low reset
hsel_i  in  1  AHB slave select
haddr_i  in  12  AHB address (block-local)
htrans_i  in  2  AHB transfer type
hwrite_i  in  1  AHB write/read
hsize_i  in  3  AHB transfer size
hburst_i  in  3  AHB burst type
hready_i  in  1  AHB bus ready (mux output)
hwdata_i  in  W  AHB write data
hrdata_o  out  W  AHB read data
hreadyout_o  out  1  slave ready
hresp_o  out  1  0=OKAY, 1=ERROR
wr_o  out  1  native write strobe, one cycle per transfer
wr_ack_i  in  1  native write acknowledge
waddr_o  out  12  native write address
wdata_o  out  W  native write data
rd_o  out  1  native read request
rd_ack_o  out  1  native read data accepted
raddr_o  out  12  native read address
rdata_i  in  W  native read data
read_valid_i  in  1  native read data valid (combinational from rd_o)
slv_error_i  in  1  native slave error, valid alongside wr_ack_i
burst_type_o  out  2  encoded burst type of current transfer

Behaviour:
- Clock clk_i; reset resetn_i, asynchronous, active-low. Reset forces IDLE, hreadyout_o=1, hresp_o=0, wr_o=0, rd_o=0, rd_ack_o=0, waddr_o/raddr_o=0, burst_type_o=0, timeout counter=0. hrdata_o=0 outside RD.
- Accept a transfer on the clk edge where hsel_i & htrans_i[1] & hready_i; register haddr, hwrite, hburst. IDLE/BUSY htrans, or hsel_i=0: no action, zero-wait OKAY.
- Legality check at accept: hsize_i must equal log2(W/8), i.e. 2 for W=32, 3 for W=64, and haddr_i[log2(W/8)-1:0] must be 0. On failure go to ERR1; no native strobe is issued.
- burst_type_o is registered at accept and held until the next accept. Encoding: SINGLE→00; INCR→01; INCR4/8/16→10; WRAP4/8/16→11.
- States: IDLE, WR_REQ, WR_WAIT, RD, ERR1, ERR2.
- WR_REQ (1 cycle): wr_o=1, waddr_o=registered addr, wdata_o=hwdata_i, hreadyout_o=0. Next state is WR_WAIT. The counter is cleared.
- WR_WAIT: wr_o=0. hreadyout_o=wr_ack_i & !slv_error_i.
  - wr_ack_i & slv_error_i → ERR1.
  - wr_ack_i alone → transfer completes OKAY; if a new transfer is accepted on that edge go to its first state, else IDLE.
  - Counter reaching TIMEOUT_CYCLES-1 without ack → ERR1.
  - Against a native side that acks the cycle after wr_o, a write completes in 2 data-phase cycles (1 wait state).
- RD: rd_o=1, raddr_o=registered addr, hrdata_o=rdata_i, hreadyout_o=read_valid_i, rd_ack_o=read_valid_i (1 cycle). This gives zero wait states when the native side decodes combinationally. No read_valid_i for TIMEOUT_CYCLES cycles → ERR1 with rd_o dropped.
- ERR1: hreadyout_o=0, hresp_o=1. ERR2: hreadyout_o=1, hresp_o=1. ERR2 may accept a new transfer like any completing cycle; otherwise it returns to IDLE.
- wr_o is never asserted for more than one cycle per AHB transfer. This prevents a double write to DIN/KEY.
- Back-to-back: an accept on the completing edge of a transfer enters WR_REQ/RD directly with no idle cycle.
- The counter saturates and does not wrap.
- Reset mid-WR_WAIT/RD returns to IDLE immediately and no completion is reported.

Test Plan:
- Write 0x0000_0001 to 0x020, SINGLE, native acks next cycle → wr_o high exactly 1 cycle with waddr_o=0x020, hreadyout_o low 1 cycle then high, hresp_o=0, burst_type_o=00.
- Read 0x030 with rdata_i=0x0000_0003, read_valid_i combinational → hrdata_o=0x3, zero wait states, rd_ack_o 1-cycle pulse.
- Read 0x0F0 with read_valid_i never asserted, TIMEOUT_CYCLES=16 → hreadyout_o low 16 cycles, then ERR1/ERR2 (hresp_o=1 for 2 cycles, hreadyout_o 0 then 1), rd_o deasserted.
- Write 0x140 with wr_ack_i=1 & slv_error_i=1 → two-cycle ERROR response, single wr_o pulse.
- haddr_i=0x022 or hsize_i=1 (W=32) → ERROR response, wr_o/rd_o never asserted.
- INCR4 write burst 0x140 ×4 then pipelined read 0x030 → 4 single wr_o pulses, burst_type_o=10 then 00 for the read. Assert resetn_i during WR_WAIT → hreadyout_o=1, wr_o=0 asynchronously.
